// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - edge trigger with hysteresis and pre-trigger circular capture buffer
// Captures DEPTH decimated samples around a qualified edge; chronological readout from the oldest sample.
module trigger_capture #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 512,
  parameter int DECIM_W = 12,
  parameter int AUTO_TO = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_vld,
  input  logic [DATA_W-1:0]        level,
  input  logic [DATA_W-1:0]        hyst,
  input  logic                     edge_sel,
  input  logic [1:0]               mode,
  input  logic [DECIM_W-1:0]       decim,
  input  logic [$clog2(DEPTH)-1:0] pretrig,
  input  logic                     arm,
  input  logic                     ack,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     done,
  output logic                     busy,
  output logic                     forced
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(AUTO_TO + 1);
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  level_l, hyst_l;
  logic               edge_l;
  logic [1:0]         mode_l;
  logic [DECIM_W-1:0] decim_l, dcnt;
  // pretrig is AW bits wide, so it can never exceed DEPTH-1: the clamp is the port width itself
  logic [AW-1:0]      pretrig_l, wptr, start, rd_idx;
  logic [AW:0]        cnt, cnt_inc, post_len;
  logic [TW-1:0]      acnt;
  logic               qual;

  logic [DATA_W:0]    lo_ext, hi_ext;
  logic [DATA_W-1:0]  lo, hi;
  logic               strobe, wr_en, qual_set, hit, real_trig, auto_trig, trig, start_acq;

  assign lo_ext = {1'b0, level_l} - {1'b0, hyst_l};
  assign hi_ext = {1'b0, level_l} + {1'b0, hyst_l};
  assign lo     = lo_ext[DATA_W] ? '0 : lo_ext[DATA_W-1:0];
  assign hi     = hi_ext[DATA_W] ? '1 : hi_ext[DATA_W-1:0];

  assign strobe    = data_vld && (dcnt == decim_l);
  assign busy      = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign done      = (state == S_DONE);
  assign wr_en     = strobe && busy && !rst;
  assign qual_set  = edge_l ? (data_in >= hi) : (data_in <= lo);
  assign hit       = edge_l ? (data_in <= level_l) : (data_in >= level_l);
  // the qualifier used is the one left by earlier samples, never the current one
  assign real_trig = strobe && qual && hit;
  assign auto_trig = strobe && (mode_l == MODE_AUTO) && (acnt == TW'(AUTO_TO - 1));
  assign trig      = (state == S_ARMED) && (real_trig || auto_trig);
  assign start_acq = ((state == S_IDLE) && arm) ||
                     ((state == S_DONE) && ack && (mode_l != MODE_SINGLE));
  assign cnt_inc   = cnt + 1'b1;
  assign post_len  = (AW+1)'(DEPTH) - {1'b0, pretrig_l};
  assign rd_idx    = start + rd_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm) state_nxt = (pretrig == '0) ? S_ARMED : S_PRE;
      S_PRE:   if (strobe && (cnt_inc == {1'b0, pretrig_l})) state_nxt = S_ARMED;
      S_ARMED: if (trig) state_nxt = (pretrig_l == AW'(DEPTH - 1)) ? S_DONE : S_POST;
      S_POST:  if (strobe && (cnt_inc == post_len)) state_nxt = S_DONE;
      S_DONE: begin
        if (ack) begin
          if (mode_l == MODE_SINGLE)   state_nxt = S_IDLE;
          else if (pretrig_l == '0)    state_nxt = S_ARMED;
          else                         state_nxt = S_PRE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_l   <= '0;
      hyst_l    <= '0;
      edge_l    <= 1'b0;
      mode_l    <= '0;
      decim_l   <= '0;
      pretrig_l <= '0;
      dcnt      <= '0;
      wptr      <= '0;
      start     <= '0;
      cnt       <= '0;
      acnt      <= '0;
      qual      <= 1'b0;
      forced    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && arm) begin
        level_l   <= level;
        hyst_l    <= hyst;
        edge_l    <= edge_sel;
        mode_l    <= mode;
        decim_l   <= decim;
        pretrig_l <= pretrig;
        dcnt      <= '0;
      end else if (data_vld) begin
        dcnt <= strobe ? '0 : dcnt + 1'b1;
      end

      if (wr_en) wptr <= wptr + 1'b1;

      if (start_acq) begin
        cnt    <= '0;
        forced <= 1'b0;
      end else if (trig) begin
        cnt    <= (AW+1)'(1);
        start  <= wptr - pretrig_l;
        forced <= !real_trig;
      end else if (wr_en && (state != S_ARMED)) begin
        cnt <= cnt_inc;
      end

      // qualifier and timeout restart every time ARMED is entered
      if (state != S_ARMED) begin
        acnt <= '0;
        qual <= 1'b0;
      end else if (strobe) begin
        acnt <= acnt + 1'b1;
        if (qual_set) qual <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_idx];
  end

endmodule

// File: tb/tb_trigger_capture.sv
// tb/tb_trigger_capture.sv - scoreboard bench for trigger_capture against a list-based capture model
module tb_trigger_capture;
  localparam int DW  = 12;
  localparam int DEP = 32;
  localparam int DCW = 4;
  localparam int ATO = 40;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_vld = 1'b0;
  logic [DW-1:0] level = '0, hyst = '0;
  logic          edge_sel = 1'b0;
  logic [1:0]    mode = '0;
  logic [DCW-1:0] decim = '0;
  logic [AW-1:0] pretrig = '0;
  logic          arm = 1'b0;
  logic          ack;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          done, busy, forced;

  int checks = 0;
  int failures = 0;
  int exp_forced[$];
  int exp_mode[$];
  int exp_data[$];
  int vq[$];
  int c_level, c_hyst, c_edge, c_mode, c_decim, c_pre;
  bit gaps;
  bit mon_active;

  trigger_capture #(.DATA_W(DW), .DEPTH(DEP), .DECIM_W(DCW), .AUTO_TO(ATO)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld), .level(level),
    .hyst(hyst), .edge_sel(edge_sel), .mode(mode), .decim(decim), .pretrig(pretrig),
    .arm(arm), .ack(ack), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
    .busy(busy), .forced(forced)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Decimate the valid-sample stream, then walk acquisitions over the kept samples.
  function automatic void build_expect();
    int st[$];
    int d, s, lo, hi, t, j;
    bit frc, flag, hitv;
    d = 0;
    foreach (vq[i]) begin
      if (d == c_decim) begin st.push_back(vq[i]); d = 0; end
      else d++;
    end
    lo = c_level - c_hyst; if (lo < 0) lo = 0;
    hi = c_level + c_hyst; if (hi > 4095) hi = 4095;
    s = 0;
    while (1) begin
      t = -1; frc = 0; flag = 0;
      for (j = s + c_pre; j < st.size(); j++) begin
        hitv = c_edge ? (st[j] <= c_level) : (st[j] >= c_level);
        if (hitv && flag) begin t = j; break; end
        if (c_mode == 2 && (j - (s + c_pre)) == ATO - 1) begin t = j; frc = 1; break; end
        if (c_edge ? (st[j] >= hi) : (st[j] <= lo)) flag = 1;
      end
      if (t < 0 || (t - c_pre + DEP) > st.size()) break;
      exp_forced.push_back(int'(frc));
      exp_mode.push_back(c_mode);
      for (int k = 0; k < DEP; k++) exp_data.push_back(st[t - c_pre + k]);
      if (c_mode == 1) break;
      s = t - c_pre + DEP;
    end
  endfunction

  task automatic step(input bit v, input int val);
    int g;
    g = 0;
    @(negedge clk);
    while (done && g < 8 * DEP) begin
      data_vld = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 8 * DEP) chk("done_release_timeout", g, 0);
    data_vld = v;
    data_in  = val[DW-1:0];
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_forced", forced, 0);
  endtask

  task automatic run(input bit chk_busy_end);
    int g;
    build_expect();
    @(negedge clk);
    level = c_level[DW-1:0]; hyst = c_hyst[DW-1:0]; edge_sel = c_edge[0];
    mode = c_mode[1:0]; decim = c_decim[DCW-1:0]; pretrig = c_pre[AW-1:0];
    arm = 1'b1; data_vld = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    level = DW'($urandom); hyst = DW'($urandom); edge_sel = 1'($urandom);
    mode = 2'($urandom); decim = DCW'($urandom); pretrig = AW'($urandom);
    foreach (vq[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, $urandom_range(0, 4095));
      step(1'b1, vq[i]);
    end
    step(1'b0, 0);
    g = 0;
    while ((exp_forced.size() != 0 || done || mon_active) && g < 40 * DEP) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", (g < 40 * DEP), 1);
    if (g >= 40 * DEP) begin exp_forced.delete(); exp_mode.delete(); exp_data.delete(); end
    if (chk_busy_end) chk("busy_at_end", busy, 1);
    reset_dut();
  endtask

  initial begin : monitor
    int ef, em;
    mon_active = 1'b0; ack = 1'b0; rd_addr = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        mon_active = 1'b1;
        chk("done_expected", (exp_forced.size() > 0), 1);
        em = 1;
        if (exp_forced.size() > 0) begin
          ef = exp_forced.pop_front();
          em = exp_mode.pop_front();
          chk("forced", forced, ef);
          chk("busy_in_done", busy, 0);
          for (int k = 0; k < DEP; k++) begin
            rd_addr = AW'(k);
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", k), rd_data, exp_data.pop_front());
          end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("done_after_ack", done, 0);
        chk("busy_after_ack", busy, (em != 1));
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p, tri_v;
    repeat (3) @(negedge clk);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_forced", forced, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b0;

    // rising ramp, single
    c_level = 2048; c_hyst = 8; c_edge = 0; c_mode = 1; c_decim = 0; c_pre = 10; gaps = 0;
    vq.delete(); for (int i = 0; i < 300; i++) vq.push_back(1900 + i);
    run(1'b0);

    // same ramp decimated by 4
    c_decim = 3;
    vq.delete(); for (int i = 0; i < 400; i++) vq.push_back(1900 + i);
    run(1'b0);

    // noisy triangle, falling edge, no pre-trigger
    c_level = 2048; c_hyst = 100; c_edge = 1; c_mode = 1; c_decim = 0; c_pre = 0; gaps = 1;
    vq.delete();
    for (int i = 0; i < 600; i++) begin
      p = i % 160;
      tri_v = (p < 80) ? p * 15 : (160 - p) * 15;
      vq.push_back(1448 + tri_v + $urandom_range(0, 100) - 50);
    end
    run(1'b0);

    // constant below level: auto mode forces a capture
    c_level = 2048; c_hyst = 8; c_edge = 0; c_mode = 2; c_decim = 0; c_pre = 5; gaps = 0;
    vq.delete(); for (int i = 0; i < 5 + ATO + DEP + 10; i++) vq.push_back(1000);
    run(1'b0);

    // same stimulus in normal mode never completes; reset aborts mid-capture
    c_mode = 0;
    run(1'b1);

    // maximum pre-trigger: trigger sample is the newest entry
    c_level = 2048; c_hyst = 50; c_edge = 0; c_mode = 1; c_decim = 0; c_pre = DEP - 1; gaps = 1;
    vq.delete(); for (int i = 0; i < 300; i++) vq.push_back($urandom_range(0, 4095));
    run(1'b0);

    // lo saturates to 0: only an exact 0 qualifies
    c_level = 4; c_hyst = 8; c_edge = 0; c_mode = 1; c_decim = 0; c_pre = 3; gaps = 0;
    vq.delete();
    for (int i = 0; i < 20; i++) vq.push_back(100);
    vq.push_back(0);
    for (int i = 0; i < 5; i++) vq.push_back(2);
    vq.push_back(10);
    for (int i = 0; i < 60; i++) vq.push_back($urandom_range(0, 4095));
    run(1'b0);

    // normal mode: repeated captures through ack restarts, then reset mid-capture
    c_level = 2048; c_hyst = 200; c_edge = 0; c_mode = 0; c_decim = 1; c_pre = 7; gaps = 1;
    vq.delete(); for (int i = 0; i < 1200; i++) vq.push_back($urandom_range(0, 4095));
    run(1'b0);

    // randomized configurations
    for (int r = 0; r < 5; r++) begin
      c_level = $urandom_range(0, 4095); c_hyst = $urandom_range(0, 300);
      c_edge = $urandom_range(0, 1); c_mode = $urandom_range(0, 3);
      c_decim = $urandom_range(0, 3); c_pre = $urandom_range(0, DEP - 1); gaps = 1;
      vq.delete(); for (int i = 0; i < 500; i++) vq.push_back($urandom_range(0, 4095));
      run(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
